// File: rtl/alu_result_checker.sv
// Response-side self-check for the 8-bit ALU: recomputes each beat with a golden model,
// counts checks and mismatches with saturation, and captures the first failing beat.
module alu_result_checker #(
    parameter int W           = 8,
    parameter int CW          = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          enable,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          c_in,
    input  logic [W-1:0]  dut_sum,
    input  logic          dut_c_out,
    output logic          chk_pulse,
    output logic          err_pulse,
    output logic [CW-1:0] check_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          halted,
    output logic          first_err_valid,
    output logic [2:0]    first_err_op,
    output logic [W-1:0]  first_err_a,
    output logic [W-1:0]  first_err_b,
    output logic [W:0]    first_err_exp,
    output logic [W:0]    first_err_got
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_SUB_A = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_NAND  = 3'd5;
    localparam logic [2:0] OP_XOR   = 3'd6;
    localparam logic [2:0] OP_XNOR  = 3'd7;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t          r_state;
    state_t          w_next_state;
    logic            w_accept;

    logic            r_s1_valid;
    logic [2:0]      r_s1_op;
    logic [W-1:0]    r_s1_a;
    logic [W-1:0]    r_s1_b;
    logic            r_s1_c_in;
    logic [W:0]      r_s1_got;

    logic [W:0]      w_add;
    logic [W:0]      w_sub;
    logic [W:0]      w_sub_a;
    logic [W:0]      w_exp;
    logic            w_mismatch;

    logic            r_chk_pulse;
    logic            r_err_pulse;
    logic [CW-1:0]   r_check_cnt;
    logic [CW-1:0]   r_err_cnt;
    logic            r_first_err_valid;
    logic [2:0]      r_first_err_op;
    logic [W-1:0]    r_first_err_a;
    logic [W-1:0]    r_first_err_b;
    logic [W:0]      r_first_err_exp;
    logic [W:0]      r_first_err_got;

    assign in_ready = (r_state == S_RUN);
    assign halted   = (r_state == S_HALT);
    assign w_accept = in_valid & in_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assigned first so no path leaves w_next_state unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if ((STOP_ON_ERR != 0) && w_mismatch) w_next_state = S_HALT;
                else if (enable)                      w_next_state = S_RUN;
            end
            S_RUN: begin
                if ((STOP_ON_ERR != 0) && w_mismatch) w_next_state = S_HALT;
                else if (!enable)                     w_next_state = S_IDLE;
            end
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c_in  <= 1'b0;
            r_s1_got   <= '0;
        end else if (clr) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c_in  <= 1'b0;
            r_s1_got   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_op    <= op;
                r_s1_a     <= a;
                r_s1_b     <= b;
                r_s1_c_in  <= c_in;
                r_s1_got   <= {dut_c_out, dut_sum};
            end
        end
    end

    // Subtractions are done one bit wider so the top bit of the result is the borrow.
    assign w_add   = {1'b0, r_s1_a} + {1'b0, r_s1_b} + {{W{1'b0}}, r_s1_c_in};
    assign w_sub   = {1'b0, r_s1_a} - {1'b0, r_s1_b} - {{W{1'b0}}, r_s1_c_in};
    assign w_sub_a = {1'b0, r_s1_b} - {1'b0, r_s1_a} - {{W{1'b0}}, r_s1_c_in};

    always_comb begin
        w_exp = '0;
        case (r_s1_op)
            OP_ADD:   w_exp = w_add;
            OP_SUB:   w_exp = w_sub;
            OP_SUB_A: w_exp = w_sub_a;
            OP_OR:    w_exp = {1'b0, r_s1_a | r_s1_b};
            OP_AND:   w_exp = {1'b0, r_s1_a & r_s1_b};
            OP_NAND:  w_exp = {1'b0, ~(r_s1_a & r_s1_b)};
            OP_XOR:   w_exp = {1'b0, r_s1_a ^ r_s1_b};
            OP_XNOR:  w_exp = {1'b0, ~(r_s1_a ^ r_s1_b)};
            default:  w_exp = '0;
        endcase
    end

    assign w_mismatch = r_s1_valid && (r_s1_got != w_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_pulse       <= 1'b0;
            r_err_pulse       <= 1'b0;
            r_check_cnt       <= '0;
            r_err_cnt         <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_op    <= '0;
            r_first_err_a     <= '0;
            r_first_err_b     <= '0;
            r_first_err_exp   <= '0;
            r_first_err_got   <= '0;
        end else if (clr) begin
            r_chk_pulse       <= 1'b0;
            r_err_pulse       <= 1'b0;
            r_check_cnt       <= '0;
            r_err_cnt         <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_op    <= '0;
            r_first_err_a     <= '0;
            r_first_err_b     <= '0;
            r_first_err_exp   <= '0;
            r_first_err_got   <= '0;
        end else begin
            r_chk_pulse <= r_s1_valid;
            r_err_pulse <= w_mismatch;
            if (r_s1_valid && (r_check_cnt != CNT_MAX)) r_check_cnt <= r_check_cnt + CW'(1);
            if (w_mismatch && (r_err_cnt != CNT_MAX))   r_err_cnt   <= r_err_cnt + CW'(1);
            if (w_mismatch && !r_first_err_valid) begin
                r_first_err_valid <= 1'b1;
                r_first_err_op    <= r_s1_op;
                r_first_err_a     <= r_s1_a;
                r_first_err_b     <= r_s1_b;
                r_first_err_exp   <= w_exp;
                r_first_err_got   <= r_s1_got;
            end
        end
    end

    assign chk_pulse       = r_chk_pulse;
    assign err_pulse       = r_err_pulse;
    assign check_cnt       = r_check_cnt;
    assign err_cnt         = r_err_cnt;
    assign first_err_valid = r_first_err_valid;
    assign first_err_op    = r_first_err_op;
    assign first_err_a     = r_first_err_a;
    assign first_err_b     = r_first_err_b;
    assign first_err_exp   = r_first_err_exp;
    assign first_err_got   = r_first_err_got;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: default, STOP_ON_ERR=1 and CW=2 instances on a
// shared stimulus bus, with a scoreboard of expected error flags for the default instance.
module tb_alu_result_checker;

    logic       clk = 1'b0;
    logic       rst_n, clr, in_valid, c_in, dut_c_out;
    logic       en0, en1, en2;
    logic [2:0] op;
    logic [7:0] a, b, dut_sum;

    logic        in_ready0, chk_pulse0, err_pulse0, halted0, fev0;
    logic [15:0] check_cnt0, err_cnt0;
    logic [2:0]  feop0;
    logic [7:0]  fea0, feb0;
    logic [8:0]  feexp0, fegot0;

    logic        in_ready1, chk_pulse1, err_pulse1, halted1, fev1;
    logic [15:0] check_cnt1, err_cnt1;
    logic [2:0]  feop1;
    logic [7:0]  fea1, feb1;
    logic [8:0]  feexp1, fegot1;

    logic        in_ready2, chk_pulse2, err_pulse2, halted2, fev2;
    logic [1:0]  check_cnt2, err_cnt2;
    logic [2:0]  feop2;
    logic [7:0]  fea2, feb2;
    logic [8:0]  feexp2, fegot2;

    int   checks = 0;
    int   errors = 0;
    bit   run0 = 1'b0;
    bit   prev_acc = 1'b0;
    bit   sb[$];

    always #5 clk = ~clk;

    alu_result_checker u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .enable(en0), .in_valid(in_valid),
        .in_ready(in_ready0), .op(op), .a(a), .b(b), .c_in(c_in), .dut_sum(dut_sum),
        .dut_c_out(dut_c_out), .chk_pulse(chk_pulse0), .err_pulse(err_pulse0),
        .check_cnt(check_cnt0), .err_cnt(err_cnt0), .halted(halted0),
        .first_err_valid(fev0), .first_err_op(feop0), .first_err_a(fea0),
        .first_err_b(feb0), .first_err_exp(feexp0), .first_err_got(fegot0)
    );

    alu_result_checker #(.STOP_ON_ERR(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .enable(en1), .in_valid(in_valid),
        .in_ready(in_ready1), .op(op), .a(a), .b(b), .c_in(c_in), .dut_sum(dut_sum),
        .dut_c_out(dut_c_out), .chk_pulse(chk_pulse1), .err_pulse(err_pulse1),
        .check_cnt(check_cnt1), .err_cnt(err_cnt1), .halted(halted1),
        .first_err_valid(fev1), .first_err_op(feop1), .first_err_a(fea1),
        .first_err_b(feb1), .first_err_exp(feexp1), .first_err_got(fegot1)
    );

    alu_result_checker #(.CW(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .enable(en2), .in_valid(in_valid),
        .in_ready(in_ready2), .op(op), .a(a), .b(b), .c_in(c_in), .dut_sum(dut_sum),
        .dut_c_out(dut_c_out), .chk_pulse(chk_pulse2), .err_pulse(err_pulse2),
        .check_cnt(check_cnt2), .err_cnt(err_cnt2), .halted(halted2),
        .first_err_valid(fev2), .first_err_op(feop2), .first_err_a(fea2),
        .first_err_b(feb2), .first_err_exp(feexp2), .first_err_got(fegot2)
    );

    // Reference result as {carry/borrow, sum}, computed in integer arithmetic.
    function automatic logic [8:0] gold(input logic [2:0] o, input logic [7:0] x,
                                        input logic [7:0] y, input logic ci);
        int r;
        case (o)
            3'd0: begin r = int'(x) + int'(y) + int'(ci); return {1'(r > 255), 8'(r)}; end
            3'd1: begin r = int'(x) - int'(y) - int'(ci); return {1'(r < 0), 8'(r)}; end
            3'd2: begin r = int'(y) - int'(x) - int'(ci); return {1'(r < 0), 8'(r)}; end
            3'd3: return {1'b0, x | y};
            3'd4: return {1'b0, x & y};
            3'd5: return {1'b0, ~(x & y)};
            3'd6: return {1'b0, x ^ y};
            default: return {1'b0, ~(x ^ y)};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic [8:0] resp);
        op        = o;
        a         = x;
        b         = y;
        c_in      = ci;
        dut_sum   = resp[7:0];
        dut_c_out = resp[8];
        in_valid  = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // One clock: predict acceptance for instance 0, then check its pulses one edge later.
    task automatic tick();
        bit acc;
        acc = in_valid && run0 && !clr && rst_n;
        if (acc) sb.push_back(gold(op, a, b, c_in) != {dut_c_out, dut_sum});
        @(posedge clk);
        #1;
        check("chk_pulse0", 32'(chk_pulse0), 32'(prev_acc));
        if (chk_pulse0 && (sb.size() > 0)) check("err_pulse0", 32'(err_pulse0), 32'(sb.pop_front()));
        prev_acc = acc;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        op = '0; a = '0; b = '0; c_in = 1'b0; dut_sum = '0; dut_c_out = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_check_cnt", 32'(check_cnt0), 0);
        check("rst_err_cnt", 32'(err_cnt0), 0);
        check("rst_in_ready", 32'(in_ready0), 0);
        check("rst_halted", 32'(halted0), 0);
        check("rst_fev", 32'(fev0), 0);
        check("rst_chk_pulse", 32'(chk_pulse0), 0);
        rst_n = 1'b1;

        en0 = 1'b1; tick(); run0 = 1'b1;
        check("run_in_ready", 32'(in_ready0), 1);

        beat(3'd0, 8'hF0, 8'h0F, 1'b0, 9'h0FF); tick(); idle(); tick();
        check("add_ok_err_cnt", 32'(err_cnt0), 0);
        check("add_ok_check_cnt", 32'(check_cnt0), 1);

        beat(3'd0, 8'hF0, 8'h0F, 1'b1, 9'h0FF); tick(); idle(); tick();
        check("add_bad_err_cnt", 32'(err_cnt0), 1);
        check("add_bad_check_cnt", 32'(check_cnt0), 2);
        check("add_bad_fev", 32'(fev0), 1);
        check("add_bad_op", 32'(feop0), 0);
        check("add_bad_exp", 32'(feexp0), 32'h100);
        check("add_bad_got", 32'(fegot0), 32'h0FF);

        clr = 1'b1; tick(); clr = 1'b0; run0 = 1'b0;
        check("clr_check_cnt", 32'(check_cnt0), 0);
        check("clr_err_cnt", 32'(err_cnt0), 0);
        check("clr_fev", 32'(fev0), 0);
        check("clr_in_ready", 32'(in_ready0), 0);
        tick(); run0 = 1'b1;
        check("rerun_in_ready", 32'(in_ready0), 1);

        beat(3'd2, 8'hF0, 8'h0F, 1'b0, 9'h11F); tick();
        beat(3'd1, 8'h39, 8'h93, 1'b1, 9'h1A5); tick();
        beat(3'd5, 8'hF0, 8'h0F, 1'b0, 9'h0FF); tick();
        beat(3'd7, 8'hF0, 8'h0F, 1'b0, 9'h000); tick();
        idle(); tick();
        check("b2b_err_cnt", 32'(err_cnt0), 0);
        check("b2b_check_cnt", 32'(check_cnt0), 4);

        beat(3'd6, 8'hAA, 8'h55, 1'b0, 9'h000); tick();
        beat(3'd3, 8'h12, 8'h34, 1'b0, 9'h136); tick();
        idle(); tick();
        check("cap_err_cnt", 32'(err_cnt0), 2);
        check("cap_check_cnt", 32'(check_cnt0), 6);
        check("cap_op", 32'(feop0), 6);
        check("cap_a", 32'(fea0), 32'hAA);
        check("cap_b", 32'(feb0), 32'h55);
        check("cap_exp", 32'(feexp0), 32'h0FF);
        check("cap_got", 32'(fegot0), 32'h000);

        beat(3'd4, 8'h3C, 8'h0F, 1'b0, 9'h00C); en0 = 1'b0; tick(); run0 = 1'b0;
        idle(); tick();
        check("endrop_check_cnt", 32'(check_cnt0), 7);
        check("endrop_in_ready", 32'(in_ready0), 0);

        en0 = 1'b1; tick(); run0 = 1'b1;
        beat(3'd0, 8'h01, 8'h01, 1'b0, 9'h002); clr = 1'b1; tick();
        clr = 1'b0; run0 = 1'b0; idle(); tick(); run0 = 1'b1;
        check("clrbeat_check_cnt", 32'(check_cnt0), 0);
        check("clrbeat_err_cnt", 32'(err_cnt0), 0);

        beat(3'd0, 8'h10, 8'h20, 1'b0, 9'h030); tick(); idle(); tick();
        check("pre_rst_check_cnt", 32'(check_cnt0), 1);
        beat(3'd0, 8'h10, 8'h20, 1'b0, 9'h030); tick(); idle();
        rst_n = 1'b0; sb.delete(); prev_acc = 1'b0; run0 = 1'b0;
        #1;
        check("midrst_chk_pulse", 32'(chk_pulse0), 0);
        check("midrst_check_cnt", 32'(check_cnt0), 0);
        check("midrst_in_ready", 32'(in_ready0), 0);
        tick();
        check("midrst_held_cnt", 32'(check_cnt0), 0);
        en0 = 1'b0; rst_n = 1'b1; tick();

        en1 = 1'b1; tick();
        check("stop_in_ready_run", 32'(in_ready1), 1);
        for (int i = 0; i < 5; i++) begin
            beat(3'd0, 8'(i), 8'h01, 1'b0, (i == 1) ? 9'h1FF : {1'b0, 8'(i + 1)});
            tick(); idle(); tick();
        end
        check("stop_halted", 32'(halted1), 1);
        check("stop_in_ready", 32'(in_ready1), 0);
        check("stop_check_cnt", 32'(check_cnt1), 2);
        check("stop_err_cnt", 32'(err_cnt1), 1);
        check("stop_fe_a", 32'(fea1), 1);
        clr = 1'b1; tick(); clr = 1'b0; en1 = 1'b0;
        check("stop_clr_check_cnt", 32'(check_cnt1), 0);
        check("stop_clr_err_cnt", 32'(err_cnt1), 0);
        check("stop_clr_halted", 32'(halted1), 0);
        check("stop_clr_fev", 32'(fev1), 0);
        check("stop_clr_in_ready", 32'(in_ready1), 0);

        en2 = 1'b1; tick();
        check("sat_in_ready", 32'(in_ready2), 1);
        for (int i = 0; i < 5; i++) begin
            beat(3'd0, 8'(i + 1), 8'h02, 1'b0, 9'h000);
            tick();
        end
        idle(); tick(); tick();
        check("sat_err_cnt", 32'(err_cnt2), 3);
        check("sat_check_cnt", 32'(check_cnt2), 3);
        check("sat_fe_op", 32'(feop2), 0);
        check("sat_fe_a", 32'(fea2), 1);
        check("sat_fe_b", 32'(feb2), 2);
        check("sat_fe_exp", 32'(feexp2), 32'h003);
        check("sat_fe_got", 32'(fegot2), 32'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Hardware self-check block at the response end of the 8-bit ALU interface: takes each applied stimulus (op, a, b, c_in) with the observed ALU response (sum, c_out) in one beat.
- Computes the expected result with an internal golden model and compares it against the observed response.
- Keeps pass/error counts and captures the first mismatch.
- Used in the ALU test harness and as an on-chip BIST monitor.

Parameters:
- W, 8, operand/sum width.
- CW, 16, width of the check and error counters.
- STOP_ON_ERR, 0, 1 = halt checking on the first mismatch.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of counters, capture registers and FSM.
- enable  input  1  checking window; 1 = run.
- in_valid  input  1  stimulus/response beat valid.
- in_ready  output  1  checker accepts a beat.
- op  input  3  opcode: 0 ADD, 1 SUB, 2 SUB_A, 3 OR, 4 AND, 5 NAND, 6 XOR, 7 XNOR.
- a, b  input  W  operands.
- c_in  input  1  carry/borrow in.
- dut_sum  input  W  observed sum.
- dut_c_out  input  1  observed carry out.
- chk_pulse  output  1  one-cycle pulse per completed check.
- err_pulse  output  1  one-cycle pulse per mismatch.
- check_cnt  output  CW  checks done.
- err_cnt  output  CW  mismatches.
- halted  output  1  FSM in HALT.
- first_err_valid  output  1  capture registers hold a mismatch.
- first_err_op  output  3  opcode of first mismatch.
- first_err_a, first_err_b  output  W  operands of first mismatch.
- first_err_exp, first_err_got  output  W+1  {c_out,sum}, expected and observed.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0; FSM in IDLE. Same state applies after clr=1 on the next edge.
- FSM states:
  - IDLE: in_ready=0; go to RUN when enable=1.
  - RUN: in_ready=1; go to IDLE when enable=0; go to HALT on a mismatch when STOP_ON_ERR=1.
  - HALT: in_ready=0, halted=1; leave only via clr or reset.
- Accept: a beat is accepted at the edge where in_valid & in_ready. Beats with in_ready=0 are ignored, not queued.
- Pipeline: accepted operands and response are registered in stage 1. Expected-result compare and counter update complete at the following edge, so chk_pulse (and err_pulse on mismatch) is high exactly one cycle after acceptance. Throughput is one beat per cycle.
- A beat accepted in the same cycle enable drops still completes its check.
- Golden model, all modulo 2^W, exp is W+1 bits {c,s}:
  - ADD: a+b+c_in, c = carry.
  - SUB: a-b-c_in, c = 1 on borrow (result negative).
  - SUB_A: b-a-c_in, c = borrow.
  - OR / AND / NAND / XOR / XNOR: bitwise result, c = 0.
- Compare: mismatch if {dut_c_out,dut_sum} != exp. c_out is always compared, including for logic ops.
- Counters:
  - check_cnt increments on every chk_pulse.
  - err_cnt increments on every err_pulse.
  - Both saturate at 2^CW-1 and never wrap.
- Capture: first_err_* load only on the first mismatch since reset/clr, setting first_err_valid. Later mismatches do not overwrite them.
- STOP_ON_ERR=1: the mismatching beat is counted. FSM enters HALT at the same edge err_pulse rises. A beat accepted in that cycle is still checked; no further beats are accepted.
- clr simultaneous with an accept or a completing check: clr wins; the beat is discarded and counters read 0.
- Reset mid-stream: the in-flight check is lost and no pulse is emitted.

Test Plan:
- ADD, a=F0, b=0F, c_in=0, dut {0,FF} -> chk_pulse one cycle after accept, err_cnt=0, check_cnt=1.
- ADD a=F0 b=0F c_in=1 with dut {0,FF} -> err_pulse; first_err_exp=1_00, first_err_got=0_FF, first_err_op=0.
- SUB_A a=F0 b=0F c_in=0 expects {1,1F}; SUB a=39 b=93 c_in=1 expects {1,A5}; NAND F0,0F expects {0,FF}; XNOR F0,0F expects {0,00}. Feed correct responses back-to-back -> 4 chk_pulses on consecutive cycles, err_cnt=0.
- STOP_ON_ERR=1, wrong response on beat 2 of 5 -> halted=1, in_ready=0, check_cnt=2, err_cnt=1; clr -> all zero, IDLE.
- CW=2, 5 mismatching beats -> err_cnt and check_cnt hold at 3; first_err_* reflect beat 1.
- Assert rst_n=0 the cycle after an accept -> no chk_pulse, outputs 0 immediately. Assert clr together with in_valid -> beat not counted.
